// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding, frame width and
// the baud divider computation also used by the TX baud generator.
package uart_rx_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  // Rounded clock-to-tick ratio: round(clk_hz / (baud * os)).
  function automatic int baud_div(input int clk_hz, input int baud, input int os);
    int den;
    den = baud * os;
    return (clk_hz + (den / 2)) / den;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte storage with push/pop/full handling. Define UART_RX_FIFO_EN for a
// DEPTH-entry FIFO; otherwise a single holding register with a valid flag is built.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 full_o,
  output logic                 drop_o
);

`ifdef UART_RX_FIFO_EN
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 push_s, pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (count_q == CNT_FULL);
  assign valid_o = (count_q != '0);
  assign pop_s   = pop_i && valid_o;
  // A pop in the same cycle frees the slot the push needs.
  assign push_s  = push_i && (!full_o || pop_s);
  assign drop_o  = push_i && !push_s;
  assign data_o  = mem_q[rd_ptr_q];

  // Storage array, pointers and occupancy count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_s) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
`else
  logic [DATA_BITS-1:0] hold_q;
  logic                 valid_q;
  logic                 push_s, pop_s;
  // Depth is fixed at one here; the parameter stays so both builds share one interface.
  logic                 unused_depth_s;

  assign unused_depth_s = (DEPTH != 0);
  assign full_o  = valid_q;
  assign valid_o = valid_q;
  assign pop_s   = pop_i && valid_q;
  assign push_s  = push_i && (!valid_q || pop_s);
  assign drop_o  = push_i && !push_s;
  assign data_o  = hold_q;

  // Single holding register and its valid flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (push_s) begin
        hold_q  <= data_i;
        valid_q <= 1'b1;
      end else if (pop_s) begin
        valid_q <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling. Storage depth is selected by UART_RX_FIFO_EN
// (see uart_rx_fifo); the port list is the same in both builds.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_uart_rx,
  input  logic                 i_rd,
  input  logic                 i_clr,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_busy,
  output logic                 o_frame_err,
  output logic                 o_overrun
);

  localparam int DIV = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 sync1_q, sync2_q, rx_prev_q, rx_s;
  logic [DW-1:0]        div_q, div_d;
  logic                 tick_s;
  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 push_s, frame_set_s, drop_s, full_s;
  logic                 frame_err_q, overrun_q;

  assign rx_s   = sync2_q;
  assign tick_s = (div_q == DIV_LAST);

  // Two-flop synchronizer plus one delayed copy for falling-edge detection; idle line is 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= i_uart_rx;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  // FSM, tick divider, counters and shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
    end
  end

  // Next-state logic; everything but the start-edge detection advances on ticks only.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    push_s      = 1'b0;
    frame_set_s = 1'b0;
    div_d       = tick_s ? '0 : div_q + DW'(1);
    case (state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d    = ST_START;
          tick_cnt_d = '0;
          div_d      = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s && (tick_cnt_q == HALF_LAST)) begin
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = rx_s ? ST_IDLE : ST_DATA;
        end else if (tick_s) begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
      ST_DATA: begin
        if (tick_s && (tick_cnt_q == TICK_LAST)) begin
          tick_cnt_d = '0;
          shreg_d    = {rx_s, shreg_q[DATA_BITS-1:1]};
          if (bit_cnt_q == BIT_LAST) begin
            state_d = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else if (tick_s) begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
      ST_STOP: begin
        if (tick_s && (tick_cnt_q == TICK_LAST)) begin
          tick_cnt_d = '0;
          if (rx_s) begin
            push_s  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_set_s = 1'b1;
            state_d     = ST_BREAK;
          end
        end else if (tick_s) begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BREAK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky error flags; a new error event wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_set_s ? 1'b1 : (i_clr ? 1'b0 : frame_err_q);
      overrun_q   <= drop_s      ? 1'b1 : (i_clr ? 1'b0 : overrun_q);
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .pop_i   (i_rd),
    .data_i  (shreg_q),
    .data_o  (o_data),
    .valid_o (o_valid),
    .full_o  (full_s),
    .drop_o  (drop_s)
  );

  assign o_busy      = (state_q != ST_IDLE);
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

  logic unused_full_s;
  assign unused_full_s = full_s;

endmodule
